// File: rtl/buffer_write_pacer_if.sv
// Upstream valid/ready word handshake for buffer_write_pacer.
// master drives in_valid/in_data; slave returns in_ready.
interface buffer_write_pacer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/buffer_write_pacer.sv
// Paces queued words into a holding buffer: one we_en pulse per word
// followed by at least GAP low cycles.
// Ports: clk, rst (async high), up (valid/ready word input), flush,
// we_en/data_out (buffer write), fifo_count, busy.
module buffer_write_pacer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int GAP    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  buffer_write_pacer_if.slave      up,
  input  logic                     flush,
  output logic                     we_en,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [GW-1:0] G_LD  = GW'(GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic [GW-1:0]     r_gap;
  logic [DATA_W-1:0] r_dout;

  logic w_ready;
  logic w_push;
  logic w_slot;
  logic w_pop;

  assign w_ready = !flush && (r_count < FULL);
  assign w_push  = up.in_valid && w_ready;

  // An issue slot is open when idle or when the gap run has expired.
  assign w_slot = (r_state == S_IDLE) ||
                  ((r_state == S_GAP) && (r_gap == '0));
  assign w_pop  = !flush && w_slot && (r_count != '0);

  assign up.in_ready = w_ready;
  assign we_en       = (r_state == S_WRITE);
  assign data_out    = r_dout;
  assign fifo_count  = r_count;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= up.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_dout  <= '0;
    end else if (flush) begin
      // data_out is deliberately kept across a flush.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_gap   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= r_mem[r_rptr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      unique case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_state <= S_GAP;
          r_gap   <= G_LD;
        end
        S_GAP: begin
          if (r_gap != '0)
            r_gap <= r_gap - GW'(1);
          else if (w_pop)
            r_state <= S_WRITE;
          else
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_write_pacer.sv
// Scoreboard bench for buffer_write_pacer (DATA_W=8, DEPTH=4, GAP=2).
// Accepted words are queued; a monitor checks each we_en pulse.
module tb_buffer_write_pacer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       we_en;
  logic [7:0] data_out;
  logic [2:0] fifo_count;
  logic       busy;

  buffer_write_pacer_if #(.DATA_W(8)) ifc ();

  buffer_write_pacer #(
    .DATA_W(8),
    .DEPTH (4),
    .GAP   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (ifc),
    .flush     (flush),
    .we_en     (we_en),
    .data_out  (data_out),
    .fifo_count(fifo_count),
    .busy      (busy)
  );

  int total;
  int bad;
  logic [7:0] exp_q[$];
  int since_we;
  bit seen_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard on we_en pulses, pulse spacing, in_ready rule.
  always @(negedge clk) begin
    if (rst) begin
      seen_we  <= 1'b0;
      since_we <= 0;
    end else begin
      check("in_ready_rule", int'(ifc.in_ready),
            int'(!flush && (fifo_count < 3'd4)));
      if (we_en) begin
        if (seen_we) check("we_spacing_ok", int'(since_we >= 3), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_we", int'(we_en), 0);
        end else begin
          check("sb_data", int'(data_out), int'(exp_q.pop_front()));
        end
        seen_we  <= 1'b1;
        since_we <= 1;
      end else begin
        since_we <= since_we + 1;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic push(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    if (acc) exp_q.push_back(d);
    else check("push_timeout", 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    check("drain_busy", int'(busy), 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    #1;
    check("rst_we", int'(we_en), 0);
    check("rst_dout", int'(data_out), 0);
    check("rst_cnt", int'(fifo_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rdy", int'(ifc.in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Single word latency and gap.
    push(8'hA5);
    check("sw_n_we", int'(we_en), 0);
    check("sw_n_cnt", int'(fifo_count), 1);
    tick();
    check("sw_n1_we", int'(we_en), 1);
    check("sw_n1_dout", int'(data_out), 8'hA5);
    tick();
    check("sw_n2_we", int'(we_en), 0);
    check("sw_n2_busy", int'(busy), 1);
    tick();
    check("sw_n3_we", int'(we_en), 0);
    check("sw_n3_busy", int'(busy), 1);
    tick();
    check("sw_n4_busy", int'(busy), 0);
    check("sw_hold_dout", int'(data_out), 8'hA5);

    // Burst 01..06, then full FIFO meets a pop with in_valid high.
    for (int k = 1; k <= 6; k++) push(8'(k));
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h07;
    @(negedge clk);
    check("full_cnt", int'(fifo_count), 4);
    check("full_rdy", int'(ifc.in_ready), 0);
    tick();
    check("full_e6_cnt", int'(fifo_count), 4);
    tick();
    check("full_e7_we", int'(we_en), 1);
    check("full_e7_cnt", int'(fifo_count), 3);
    @(negedge clk);
    check("full_e7_rdy", int'(ifc.in_ready), 1);
    tick();
    check("full_e8_cnt", int'(fifo_count), 4);
    ifc.in_valid = 1'b0;
    exp_q.push_back(8'h07);
    drain();
    check("burst_last_dout", int'(data_out), 8'h07);

    // Flush during GAP with 2 words still queued.
    push(8'h11);
    push(8'h12);
    push(8'h13);
    flush = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h99;
    exp_q.delete();
    @(negedge clk);
    check("fl_rdy", int'(ifc.in_ready), 0);
    tick();
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    check("fl_cnt", int'(fifo_count), 0);
    check("fl_we", int'(we_en), 0);
    check("fl_busy", int'(busy), 0);
    check("fl_dout", int'(data_out), 8'h11);
    repeat (6) tick();
    check("fl_dout_hold", int'(data_out), 8'h11);
    check("fl_cnt_hold", int'(fifo_count), 0);

    // Async reset while we_en is high, with a word pending.
    push(8'h55);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h56;
    tick();
    ifc.in_valid = 1'b0;
    check("ar_pre_we", int'(we_en), 1);
    check("ar_pre_cnt", int'(fifo_count), 1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("ar_we", int'(we_en), 0);
    check("ar_dout", int'(data_out), 0);
    check("ar_cnt", int'(fifo_count), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_rdy", int'(ifc.in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    push(8'h3C);
    check("ar_n_we", int'(we_en), 0);
    tick();
    check("ar_n1_we", int'(we_en), 1);
    check("ar_n1_dout", int'(data_out), 8'h3C);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_write_pacer.md
Name: buffer_write_pacer

Overview:
- Upstream feeder for the 8-bit write-enabled holding buffer.
- The holding buffer captures data on a one-cycle we_en pulse. It only forwards its stored word to its output on cycles where we_en is low.
- This block accepts words over a valid/ready interface and queues them in a small FIFO. It issues each word as a single-cycle we_en pulse followed by a guaranteed run of we_en-low cycles, so every write propagates downstream before the next write arrives.

Parameters:
- DATA_W, 8, width of data path.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- GAP, 2, minimum we_en-low cycles after each we_en pulse; >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  FIFO can accept; combinational: !flush && (count < DEPTH).
- flush  input  1  synchronous clear of FIFO and FSM.
- we_en  output  1  write strobe to holding buffer; high exactly one cycle per word.
- data_out  output  DATA_W  word presented with we_en; holds last issued word otherwise.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  (state != IDLE) || (fifo_count != 0).

Behaviour:
- Reset (rst=1, asynchronous):
  - Clears FIFO pointers and count, and sets state=IDLE.
  - Outputs: we_en=0, data_out=0, fifo_count=0, busy=0, in_ready=1 (when flush=0).
  - Reset asserted mid-operation drops we_en immediately. Queued words are discarded.
- FIFO:
  - Push on the edge where in_valid && in_ready.
  - Pop on the edge where the FSM enters WRITE.
  - Simultaneous push and pop leaves count unchanged. A push is legal when full only if a pop occurs the same edge? No: in_ready stays low when count==DEPTH, so a full FIFO takes no push even if a pop occurs that edge.
  - Read and write pointers wrap modulo DEPTH.
  - in_valid while in_ready=0 is ignored; the upstream holds the word.
- FSM states:
  - IDLE: we_en=0. If count>0 at the edge, pop the head into data_out and go to WRITE.
  - WRITE: we_en=1 for this single cycle; data_out is the popped word. Always go to GAP next, loading gap_cnt=GAP-1.
  - GAP: we_en=0.
    - If gap_cnt != 0, decrement it.
    - If gap_cnt == 0 and count>0, pop into data_out and go to WRITE.
    - If gap_cnt == 0 and count==0, go to IDLE.
- we_en is decoded from registered state (state==WRITE). data_out is registered; both are glitch-free.
- Latency: a word pushed at edge N into an empty FIFO in IDLE drives we_en=1 during the cycle after edge N+1.
- Throughput: at most one word per GAP+1 cycles. The we_en low run between consecutive pulses is exactly GAP cycles when the FIFO is non-empty.
- data_out changes only on entry to WRITE. It holds its value through GAP, IDLE and flush.
- flush (synchronous, higher priority than push/pop):
  - Clears count and pointers; state goes to IDLE, so we_en=0 the next cycle.
  - data_out is retained.
  - A word presented with in_valid during flush is not accepted (in_ready=0).
  - flush while in WRITE: the current pulse completes that cycle (already issued); no further words are issued.
- fifo_count reflects the registered count after each edge. No overflow or underflow is possible by construction.

Test Plan:
- Reset: assert rst with traffic pending -> we_en=0, data_out=0x00, fifo_count=0, busy=0, in_ready=1, all with no clock edge required.
- Single word: push 0xA5 at edge N from idle -> we_en=1 with data_out=0xA5 in the cycle after edge N+1 only; then we_en=0 for >=2 cycles; busy returns 0 after the GAP cycles.
- Burst with DEPTH=4, GAP=2: push 0x01..0x06 back-to-back -> in_ready goes 0 at count=4. we_en pulses every 3 cycles carrying 0x01..0x06 in order, never two highs within 3 cycles. All words are delivered and none is lost.
- Simultaneous push/pop when full: at count=4, FSM enters WRITE with in_valid=1 -> no push that edge (in_ready=0); count=3 afterwards; the next push is accepted on the following edge.
- Flush mid-burst: 3 words queued, flush for 1 cycle while in GAP -> fifo_count=0 and state IDLE. No further we_en. data_out keeps the last issued word, and in_valid=1 during the flush cycle is not accepted.
- Async reset during WRITE: rst rises mid-cycle while we_en=1 -> we_en falls before the next edge. After rst deasserts, a fresh push of 0x3C is issued normally with the single-word latency.
